// File: rtl/spi_frame_reader.sv
// spi_frame_reader
//
// Reads NUM_FRAMES frames from SPI flash with one READ (0x03) command per
// frame and OR-composites them into a single DATA_BITS-wide image. Frame 0
// is loaded as-is; every later frame is ORed in while the image rotates
// through the shift register. SPI runs in mode 0 at clk/2. SCK, MOSI and CS
// are all driven straight from flops.
//
// Ports:
//   clk, rst      sole clock and synchronous active-high reset
//   start         one-cycle request, honoured only while busy is low
//   frames        NUM_FRAMES packed frame indices, frame k at [k*IDX_W +: IDX_W]
//   busy          high while a sequence is in flight
//   done          one-cycle pulse when the composite image is complete
//   data          composited image, MSB is the first bit read from flash
//   spi_cs        flash chip select (active low)
//   spi_sck       SPI clock, idles low
//   spi_si        MOSI, low whenever no command bit is being sent
//   spi_so        MISO
//
// Optional feature: define SPI_FRAME_DBUF_EN to present data from a shadow
// register that updates only when done pulses. Without it, data is the
// working shift register, and intermediate shift states are visible.

module spi_frame_reader #(
    parameter int          DATA_BITS  = 8192,
    parameter int          NUM_FRAMES = 3,
    parameter int          IDX_W      = 8,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          CS_GAP     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_FRAMES*IDX_W-1:0] frames,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_BITS-1:0]        data,
    output logic                        spi_cs,
    output logic                        spi_sck,
    output logic                        spi_si,
    input  logic                        spi_so
);

    localparam int BW = $clog2(DATA_BITS > 32 ? DATA_BITS : 32);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [23:0]   FRAME_BYTES = 24'(DATA_BITS / 8);
    localparam logic [7:0]    READ_CMD    = 8'h03;
    localparam logic [BW-1:0] CMD_LAST    = BW'(31);
    localparam logic [BW-1:0] DATA_LAST   = BW'(DATA_BITS - 1);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(NUM_FRAMES - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        GAP,
        FIN
    } state_t;

    state_t                        state, state_n;
    logic [FW-1:0]                 f, f_n;
    logic [BW-1:0]                 bit_cnt, bit_cnt_n;
    logic [GW-1:0]                 gap_cnt, gap_cnt_n;
    logic [31:0]                   cmd_sr, cmd_sr_n;
    logic [NUM_FRAMES*IDX_W-1:0]   frames_q, frames_q_n;
    logic [DATA_BITS-1:0]          work, work_n;
    logic                          cs_n, sck_n, si_n, busy_n, done_n;
    logic [31:0]                   next_word;
    logic                          shift_bit;

    // Full READ command for one frame index. The address arithmetic is kept
    // to 24 bits, so a large index simply wraps around the flash space.
    function automatic logic [31:0] cmd_word(input logic [IDX_W-1:0] idx);
        logic [23:0] addr;
        addr = BASE_ADDR + 24'(idx) * FRAME_BYTES;
        return {READ_CMD, addr};
    endfunction

    // Select one index out of the packed vector. The loop uses only constant
    // slices, so no out-of-range select can be built when NUM_FRAMES is 1.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_FRAMES*IDX_W-1:0] v,
                                              input logic [FW-1:0] k);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            if (k == FW'(i)) r = v[i*IDX_W +: IDX_W];
        end
        return r;
    endfunction

    // Every output and counter is a flop. This block only computes the next
    // values. The SPI phase is taken from spi_sck itself: low means phase L and
    // high means phase H. A bit completes on the edge that leaves phase H.
    // MISO is sampled and the next MOSI bit is launched on that same edge.
    always_comb begin
        state_n    = state;
        f_n        = f;
        bit_cnt_n  = bit_cnt;
        gap_cnt_n  = gap_cnt;
        cmd_sr_n   = cmd_sr;
        frames_q_n = frames_q;
        work_n     = work;
        cs_n       = spi_cs;
        sck_n      = spi_sck;
        si_n       = spi_si;
        busy_n     = busy;
        done_n     = 1'b0;
        next_word  = '0;
        shift_bit  = spi_so;

        case (state)
            IDLE: begin
                if (start) begin
                    frames_q_n = frames;
                    next_word  = cmd_word(pick(frames, '0));
                    cmd_sr_n   = {next_word[30:0], 1'b0};
                    si_n       = next_word[31];
                    f_n        = '0;
                    bit_cnt_n  = '0;
                    cs_n       = 1'b0;
                    sck_n      = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = CMD;
                end
            end

            CMD: begin
                if (!spi_sck) begin
                    sck_n = 1'b1;
                end else begin
                    sck_n = 1'b0;
                    if (bit_cnt == CMD_LAST) begin
                        si_n      = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = DATA;
                    end else begin
                        si_n      = cmd_sr[31];
                        cmd_sr_n  = {cmd_sr[30:0], 1'b0};
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (!spi_sck) begin
                    sck_n = 1'b1;
                end else begin
                    sck_n = 1'b0;
                    // Later frames OR into the bit that rotates out of the top,
                    // so after DATA_BITS shifts every bit is back in place.
                    shift_bit = (f == '0) ? spi_so : (spi_so | work[DATA_BITS-1]);
                    work_n    = {work[DATA_BITS-2:0], shift_bit};
                    if (bit_cnt == DATA_LAST) begin
                        cs_n      = 1'b1;
                        bit_cnt_n = '0;
                        gap_cnt_n = '0;
                        state_n   = GAP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = '0;
                    if (f == FRAME_LAST) begin
                        state_n = FIN;
                    end else begin
                        f_n       = f + 1'b1;
                        next_word = cmd_word(pick(frames_q, f + 1'b1));
                        cmd_sr_n  = {next_word[30:0], 1'b0};
                        si_n      = next_word[31];
                        cs_n      = 1'b0;
                        state_n   = CMD;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end

            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output register. Reset puts the bus back to idle at once,
    // so an aborted sequence just disappears without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            f        <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            cmd_sr   <= '0;
            frames_q <= '0;
            work     <= '0;
            spi_cs   <= 1'b1;
            spi_sck  <= 1'b0;
            spi_si   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            f        <= f_n;
            bit_cnt  <= bit_cnt_n;
            gap_cnt  <= gap_cnt_n;
            cmd_sr   <= cmd_sr_n;
            frames_q <= frames_q_n;
            work     <= work_n;
            spi_cs   <= cs_n;
            spi_sck  <= sck_n;
            spi_si   <= si_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

`ifdef SPI_FRAME_DBUF_EN
    logic [DATA_BITS-1:0] shadow;

    // Shadow copy for consumers that read data at any time. It updates on
    // the FIN edge, which is the same edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (state == FIN) begin
            shadow <= work;
        end
    end

    assign data = shadow;
`else
    assign data = work;
`endif

endmodule
